// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RV32 pipeline.
// Resolves memory wait, MUL/DIV, redirect and load-use hazards with
// same-cycle control outputs, and keeps saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_memread,
  input  logic             ex_is_mdu,
  input  logic             ex_branch_taken,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mdu_start,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             mem_wait_s;
  logic             load_use_s;
  logic             redirect_s;

  // Saturating increment shared by both performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Hazard detection; x0 as destination never creates a load-use dependency.
  always_comb begin
    mem_wait_s = mem_req && !dmem_ready;
    load_use_s = ex_memread && (ex_rd_addr != 5'd0) &&
                 ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                  (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
  end

  // Same-cycle control decode by priority, plus next state and counter updates.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    mdu_start    = 1'b0;
    redirect_s   = 1'b0;
    state_d      = state_q;
    case (state_q)
      ST_RUN: begin
        if (mem_wait_s) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
        end else if (ex_is_mdu) begin
          mdu_start    = 1'b1;
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          state_d      = ST_MDU_WAIT;
        end else if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          redirect_s   = 1'b1;
        end else if (load_use_s) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_flush  = 1'b1;
        end else begin
          state_d      = ST_RUN;
        end
      end
      ST_MDU_WAIT: begin
        // MEM holds a bubble while waiting, so mem_req is not consulted here.
        if (mdu_done) begin
          state_d      = ST_RUN;
        end else begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
        end
      end
      default: begin
        state_d        = ST_RUN;
      end
    endcase
    // Reset dominates: freeze every stage register and bubble everything.
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      mdu_start    = 1'b0;
      redirect_s   = 1'b0;
    end else begin
      redirect_s   = redirect_s;
    end
    stall_d = pc_en      ? stall_q : sat_inc(stall_q);
    flush_d = redirect_s ? sat_inc(flush_q) : flush_q;
  end

  // FSM state and performance counters; reset aborts any MDU wait immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      stall_q <= {CNT_W{1'b0}};
      flush_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign ctrl_state   = state_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table-driven directed vectors plus hand sequences for
// asynchronous reset during an MDU wait and counter saturation (CNT_W=4).
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic             id_uses_rs1, id_uses_rs2;
  logic             ex_memread, ex_is_mdu, ex_branch_taken, mdu_done;
  logic             mem_req, dmem_ready;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic             mdu_start;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int tests_run;
  int tests_failed;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_memread(ex_memread), .ex_is_mdu(ex_is_mdu),
    .ex_branch_taken(ex_branch_taken), .mdu_done(mdu_done),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .mdu_start(mdu_start), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, mdu, br, done, req, rdy;
    logic [4:0] en;     // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [3:0] fl;     // {if_id, id_ex, ex_mem, mem_wb}
    logic       st;
    logic [1:0] cs;
    logic [3:0] stall, fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic mr, input logic mdu, input logic br,
                              input logic done, input logic req, input logic rdy,
                              input logic [4:0] en, input logic [3:0] fl,
                              input logic st, input logic [1:0] cs,
                              input logic [3:0] stall, input logic [3:0] fc);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.mdu = mdu; v.br = br; v.done = done; v.req = req; v.rdy = rdy;
    v.en = en; v.fl = fl; v.st = st; v.cs = cs; v.stall = stall; v.fc = fc;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
    id_uses_rs1 = v.u1;  id_uses_rs2 = v.u2;
    ex_rd_addr = v.rd;   ex_memread = v.mr;
    ex_is_mdu = v.mdu;   ex_branch_taken = v.br;
    mdu_done = v.done;   mem_req = v.req; dmem_ready = v.rdy;
  endtask

  task automatic idle();
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             5'd0, 4'd0, 1'b0, 2'd0, 4'd0, 4'd0));
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [4:0] en, input logic [3:0] fl,
                           input logic st, input logic [1:0] cs,
                           input logic [3:0] stall, input logic [3:0] fc);
    logic [4:0] a_en;
    logic [3:0] a_fl;
    a_en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    a_fl = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    tests_run++;
    if ({a_en, a_fl, mdu_start, ctrl_state, stall_cycles, flush_count} !==
        {en, fl, st, cs, stall, fc}) begin
      tests_failed++;
      $display("FAIL %s: got en=%b fl=%b start=%b state=%0d stall=%0d fc=%0d, expected en=%b fl=%b start=%b state=%0d stall=%0d fc=%0d",
               name, a_en, a_fl, mdu_start, ctrl_state, stall_cycles, flush_count,
               en, fl, st, cs, stall, fc);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    idle();

    //            rs1   rs2  u1 u2  rd   mr mdu br dn rq rdy  en        fl      st cs stall fc
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'b11111,4'b0000,1'b0,2'd0,4'd0,4'd0));   // idle
    vecs.push_back(mk(5'd0,5'd5,1'b0,1'b1,5'd5,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'b00111,4'b0100,1'b0,2'd0,4'd0,4'd0));   // load-use rs2
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,5'b11111,4'b0000,1'b0,2'd0,4'd1,4'd0));   // load in MEM
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b1,5'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'b11111,4'b0000,1'b0,2'd0,4'd1,4'd0));   // rd=x0
    vecs.push_back(mk(5'd0,5'd5,1'b0,1'b1,5'd5,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'b11111,4'b1100,1'b0,2'd0,4'd1,4'd0));   // redirect beats load-use
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'b11111,4'b0000,1'b0,2'd0,4'd1,4'd1));   // idle
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,5'b00001,4'b0001,1'b0,2'd0,4'd1,4'd1));   // mem wait 1
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,5'b00001,4'b0001,1'b0,2'd0,4'd2,4'd1));   // mem wait 2
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,5'b00001,4'b0001,1'b0,2'd0,4'd3,4'd1));   // mem wait 3
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,5'b11111,4'b1100,1'b0,2'd0,4'd4,4'd1));   // ready -> redirect
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'b11111,4'b0000,1'b0,2'd0,4'd4,4'd2));   // idle
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'b00011,4'b0010,1'b1,2'd0,4'd4,4'd2));   // mdu start
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'b00011,4'b0010,1'b0,2'd1,4'd5,4'd2));   // wait 1
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,5'b00011,4'b0010,1'b0,2'd1,4'd6,4'd2));   // wait 2, mem_req ignored
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'b00011,4'b0010,1'b0,2'd1,4'd7,4'd2));   // wait 3
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'b00011,4'b0010,1'b0,2'd1,4'd8,4'd2));   // wait 4
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'b11111,4'b0000,1'b0,2'd1,4'd9,4'd2));   // done
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'b11111,4'b0000,1'b0,2'd0,4'd9,4'd2));   // back in RUN
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'b11111,4'b0000,1'b0,2'd0,4'd9,4'd2));   // done ignored in RUN
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,5'b00001,4'b0001,1'b0,2'd0,4'd9,4'd2));   // mem wait beats mdu
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,5'b00011,4'b0010,1'b1,2'd0,4'd10,4'd2));  // then mdu starts
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'b11111,4'b0000,1'b0,2'd1,4'd11,4'd2));  // immediate done
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'b11111,4'b0000,1'b0,2'd0,4'd11,4'd2));  // idle
    vecs.push_back(mk(5'd7,5'd0,1'b1,1'b0,5'd7,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'b00111,4'b0100,1'b0,2'd0,4'd11,4'd2));  // load-use rs1
    vecs.push_back(mk(5'd7,5'd7,1'b0,1'b0,5'd7,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'b11111,4'b0000,1'b0,2'd0,4'd12,4'd2));  // match but unused
    vecs.push_back(mk(5'd0,5'd0,1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'b11111,4'b0000,1'b0,2'd0,4'd12,4'd2));  // idle

    // Reset state.
    #2;
    check_all("reset", 5'b00000, 4'b1111, 1'b0, 2'd0, 4'd0, 4'd0);
    #10 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].fl, vecs[i].st,
                vecs[i].cs, vecs[i].stall, vecs[i].fc);
    end

    // Asynchronous reset in the middle of an MDU wait.
    @(posedge clk);
    #1;
    idle();
    ex_is_mdu = 1'b1;
    @(negedge clk);
    check("mdu_start_pulse", {31'd0, mdu_start}, 32'd1);
    @(posedge clk);
    #1;
    check("in_mdu_wait", {30'd0, ctrl_state}, 32'd1);
    check("no_second_start", {31'd0, mdu_start}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_all("async_reset", 5'b00000, 4'b1111, 1'b0, 2'd0, 4'd0, 4'd0);
    ex_is_mdu = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_all("after_release", 5'b11111, 4'b0000, 1'b0, 2'd0, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    check_all("after_release_edge", 5'b11111, 4'b0000, 1'b0, 2'd0, 4'd0, 4'd0);

    // Saturation of stall_cycles: 20 stalled cycles on a 4-bit counter.
    mem_req = 1'b1;
    dmem_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("stall_saturate", {28'd0, stall_cycles}, 32'd15);

    // Saturation of flush_count: 20 redirects.
    mem_req = 1'b0;
    ex_branch_taken = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("flush_saturate", {28'd0, flush_count}, 32'd15);
    check("stall_hold", {28'd0, stall_cycles}, 32'd15);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
